grf: RTL and testbench
======================

GRF -- requirements
Module: grf

Interface
REQ-001 Parameter BYPASS, default 1: 1 routes same-cycle write data to the read ports; 0 means reads return stored contents only.
REQ-002 Parameter CNT_W, default 16: width of the committed-write counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ra1  input  5  read address, port 1 (rs).
REQ-006 ra2  input  5  read address, port 2 (rt).
REQ-007 rd1  output  32  read data, port 1.
REQ-008 rd2  output  32  read data, port 2.
REQ-009 we  input  1  write enable (RegWrite).
REQ-010 wa  input  5  write address from the write-register select (rt, rd or 31).
REQ-011 wd  input  32  write data from the write-data select (ALU result, DM data or PC link).
REQ-012 pc  input  32  PC of the instruction currently writing back; used for trace only.
REQ-013 trace_valid  output  1  one-cycle pulse reporting a committed write.
REQ-014 trace_pc  output  32  PC of the reported write.
REQ-015 trace_addr  output  5  register number of the reported write.
REQ-016 trace_data  output  32  value of the reported write.
REQ-017 wr_count  output  CNT_W  number of committed writes since reset.

Function
REQ-018 Storage: 31 registers of 32 bits, numbered 1-31. Register 0 has no storage and always reads 32'h0.
REQ-019 Commit: a write commits on the rising edge when we=1 and wa!=0; reg[wa] takes wd.
REQ-020 Writes with wa=0 are discarded: no state change, no trace, no count increment.
REQ-021 Reads are combinational, with zero latency from ra1, ra2 or register state.
REQ-022 Bypass, BYPASS=1: if we=1, wa!=0 and ra1==wa, then rd1=wd in the same cycle. rd2 follows the same rule with ra2.
REQ-023 When BYPASS=0, reads return pre-edge register contents until the commit edge.
REQ-024 If ra1==ra2, both ports return the same value under every rule.
REQ-025 Trace: on the commit edge, trace_valid<=1, trace_pc<=pc, trace_addr<=wa and trace_data<=wd. These are visible one cycle after the write is presented.
REQ-026 trace_valid returns to 0 on the next edge that has no commit. Back-to-back commits keep trace_valid high and update the payload every cycle.
REQ-027 trace_pc, trace_addr and trace_data hold their last values while trace_valid=0.
REQ-028 wr_count increments by 1 on each commit and saturates at all-ones; it does not wrap.
REQ-029 If any bit of we or wa is X while clk rises, the simulation model flags an error; no register is written.

Reset
REQ-030 Asserting reset_n low clears registers 1-31 to 0 immediately, independent of clk.
REQ-031 During reset: trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0, wr_count=0.
REQ-032 While reset_n=0, writes are ignored and rd1/rd2 read 0.
REQ-033 A write presented at the edge coincident with reset deassertion does not commit; the first commit occurs at the first edge with reset_n high.
REQ-034 Reset asserted between a commit edge and trace observation clears the trace; the write is not reported.

Verification
REQ-035 Reset, then we=1, wa=5, wd=32'h1234_5678, pc=32'h0000_3000 for one edge -> reg5 reads 32'h1234_5678 on ra1=5; the next cycle shows trace_valid=1, trace_addr=5, trace_pc=32'h0000_3000; wr_count=1.
REQ-036 we=1, wa=0, wd=32'hFFFF_FFFF -> ra1=0 reads 0; no trace pulse; wr_count unchanged.
REQ-037 BYPASS=1, reg8=32'h11, then we=1, wa=8, wd=32'h22, ra1=ra2=8 in the same cycle -> rd1=rd2=32'h22 before the edge. With BYPASS=0 -> 32'h11 before the edge, 32'h22 after.
REQ-038 Three consecutive commits to regs 1, 2, 31 (31 = link, wd=pc+8) -> trace_valid high for 3 cycles with payload matching each write, then low; wr_count=3.
REQ-039 CNT_W=4: 17 commits -> wr_count stops at 4'hF.
REQ-040 Pulse reset_n low mid-cycle after writing reg9=32'hABCD -> rd reads 0 immediately, with no clk edge needed; trace and count are 0.

Source files
------------

// File: rtl/grf.sv
// grf -- 31 x 32-bit general register file with a write-back trace port.
//
// Register 0 has no storage and always reads zero. Two combinational read
// ports, one write port. A write commits on the rising clock edge when
// we=1, wa!=0 and reset_n is high. Each commit is reported one cycle later
// on the trace outputs and counted in a saturating counter.
//
// Parameters
//   BYPASS   1: a committing write is forwarded to a read port addressing
//               the same register in the same cycle.
//            0: reads return stored contents only.
//   CNT_W    width of the committed-write counter
//
// Ports
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   ra1, ra2     read addresses (rs, rt)
//   rd1, rd2     read data
//   we, wa, wd   write enable / address / data
//   pc           PC of the writing instruction (trace only)
//   trace_valid  one-cycle pulse per committed write
//   trace_pc     PC of the reported write
//   trace_addr   register number of the reported write
//   trace_data   value of the reported write
//   wr_count     committed writes since reset, saturating
module grf #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [31:0]      wd,
    input  logic [31:0]      pc,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] wr_count
);

    logic [31:0]      r_regs [1:31];
    logic             r_trace_valid;
    logic [31:0]      r_trace_pc;
    logic [4:0]       r_trace_addr;
    logic [31:0]      r_trace_data;
    logic [CNT_W-1:0] r_wr_count;

    logic             w_commit;
    logic [31:0]      w_rd1;
    logic [31:0]      w_rd2;

    // reset_n is part of the qualifier so that a write held on the bus
    // during reset neither commits nor leaks through the bypass path.
    assign w_commit = reset_n && we && (wa != 5'd0);

    // Register storage; cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (w_commit) begin
            r_regs[wa] <= wd;
        end
    end

    // Trace payload is only loaded on a commit, so it holds its last value
    // while trace_valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= 32'h0;
            r_trace_addr  <= 5'd0;
            r_trace_data  <= 32'h0;
        end else begin
            r_trace_valid <= w_commit;
            if (w_commit) begin
                r_trace_pc   <= pc;
                r_trace_addr <= wa;
                r_trace_data <= wd;
            end
        end
    end

    // Saturating commit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_count <= '0;
        end else if (w_commit && (r_wr_count != {CNT_W{1'b1}})) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

    // Combinational read ports. Both ports use the identical rule, so equal
    // addresses always give equal data.
    always_comb begin
        w_rd1 = 32'h0;
        if (ra1 != 5'd0) begin
            if ((BYPASS != 0) && w_commit && (ra1 == wa)) begin
                w_rd1 = wd;
            end else begin
                w_rd1 = r_regs[ra1];
            end
        end
    end

    always_comb begin
        w_rd2 = 32'h0;
        if (ra2 != 5'd0) begin
            if ((BYPASS != 0) && w_commit && (ra2 == wa)) begin
                w_rd2 = wd;
            end else begin
                w_rd2 = r_regs[ra2];
            end
        end
    end

    assign rd1         = w_rd1;
    assign rd2         = w_rd2;
    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;
    assign wr_count    = r_wr_count;

    // Simulation-only guard: an unknown write control at the clock edge is
    // an error. The commit qualifier evaluates false on X, so nothing is
    // written in that case.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!$isunknown({we, wa}));
        end
    end

endmodule

// File: tb/tb_grf.sv
module tb_grf;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ra1, ra2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;

    // default instance: BYPASS=1, CNT_W=16
    logic [31:0] rd1_a, rd2_a, tpc_a, tdata_a;
    logic        tvalid_a;
    logic [4:0]  taddr_a;
    logic [15:0] cnt_a;

    // alternate instance: BYPASS=0, CNT_W=4
    logic [31:0] rd1_b, rd2_b, tpc_b, tdata_b;
    logic        tvalid_b;
    logic [4:0]  taddr_b;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    grf u_dut (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_a), .rd2(rd2_a), .we(we), .wa(wa), .wd(wd), .pc(pc),
        .trace_valid(tvalid_a), .trace_pc(tpc_a), .trace_addr(taddr_a),
        .trace_data(tdata_a), .wr_count(cnt_a)
    );

    grf #(.BYPASS(0), .CNT_W(4)) u_alt (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b), .rd2(rd2_b), .we(we), .wa(wa), .wd(wd), .pc(pc),
        .trace_valid(tvalid_b), .trace_pc(tpc_b), .trace_addr(taddr_b),
        .trace_data(tdata_b), .wr_count(cnt_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a write, take one rising edge, sample 1 ns later. we is left
    // as driven so back-to-back writes need no idle cycle.
    task automatic write_edge(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        we = 1'b1;
        wa = a;
        wd = d;
        pc = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_edge();
        we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        ra1 = 5'd5; ra2 = 5'd0;
        we = 1'b0; wa = 5'd0; wd = 32'h0; pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd1", rd1_a, 32'h0);
        check("rst_tvalid", {31'h0, tvalid_a}, 32'h0);
        check("rst_tpc", tpc_a, 32'h0);
        check("rst_cnt", {16'h0, cnt_a}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // basic write to reg5
        we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; pc = 32'h0000_3000; ra1 = 5'd5;
        #1;
        check("byp_pre_edge", rd1_a, 32'h1234_5678);
        check("nobyp_pre_edge", rd1_b, 32'h0);
        write_edge(5'd5, 32'h1234_5678, 32'h0000_3000);
        we = 1'b0;
        #1;
        check("w5_rd1", rd1_a, 32'h1234_5678);
        check("w5_rd1_alt", rd1_b, 32'h1234_5678);
        check("w5_tvalid", {31'h0, tvalid_a}, 32'h1);
        check("w5_taddr", {27'h0, taddr_a}, 32'd5);
        check("w5_tpc", tpc_a, 32'h0000_3000);
        check("w5_tdata", tdata_a, 32'h1234_5678);
        check("w5_cnt", {16'h0, cnt_a}, 32'd1);

        // write to reg0 is discarded
        ra1 = 5'd0;
        write_edge(5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
        check("r0_rd1", rd1_a, 32'h0);
        check("r0_tvalid", {31'h0, tvalid_a}, 32'h0);
        check("r0_tpc_hold", tpc_a, 32'h0000_3000);
        check("r0_taddr_hold", {27'h0, taddr_a}, 32'd5);
        check("r0_cnt", {16'h0, cnt_a}, 32'd1);

        // bypass vs no bypass on reg8
        write_edge(5'd8, 32'h11, 32'h0000_3008);
        we = 1'b1; wa = 5'd8; wd = 32'h22; ra1 = 5'd8; ra2 = 5'd8;
        #1;
        check("byp_rd1", rd1_a, 32'h22);
        check("byp_rd2", rd2_a, 32'h22);
        check("nobyp_rd1", rd1_b, 32'h11);
        check("nobyp_rd2", rd2_b, 32'h11);
        write_edge(5'd8, 32'h22, 32'h0000_300C);
        check("nobyp_post_rd1", rd1_b, 32'h22);
        check("nobyp_post_rd2", rd2_b, 32'h22);
        check("byp_post_rd1", rd1_a, 32'h22);

        // three back-to-back commits, last one is the link register
        write_edge(5'd1, 32'hA1, 32'h100);
        check("b2b1_tvalid", {31'h0, tvalid_a}, 32'h1);
        check("b2b1_taddr", {27'h0, taddr_a}, 32'd1);
        check("b2b1_tdata", tdata_a, 32'hA1);
        write_edge(5'd2, 32'hA2, 32'h104);
        check("b2b2_tvalid", {31'h0, tvalid_a}, 32'h1);
        check("b2b2_taddr", {27'h0, taddr_a}, 32'd2);
        check("b2b2_tpc", tpc_a, 32'h104);
        write_edge(5'd31, 32'h110, 32'h108);
        check("b2b3_tvalid", {31'h0, tvalid_a}, 32'h1);
        check("b2b3_taddr", {27'h0, taddr_a}, 32'd31);
        check("b2b3_tdata", tdata_a, 32'h110);
        check("b2b3_tpc", tpc_a, 32'h108);
        idle_edge();
        check("b2b_end_tvalid", {31'h0, tvalid_a}, 32'h0);
        check("b2b_end_tdata_hold", tdata_a, 32'h110);
        check("b2b_cnt", {16'h0, cnt_a}, 32'd6);
        ra1 = 5'd1; ra2 = 5'd31;
        #1;
        check("rd_r1", rd1_a, 32'hA1);
        check("rd_r31", rd2_a, 32'h110);

        // counter saturation on the 4-bit instance (6 commits so far)
        for (int i = 0; i < 9; i++) begin
            write_edge(5'(10 + i), 32'(i), 32'h200);
        end
        check("sat_alt_15", {28'h0, cnt_b}, 32'd15);
        check("sat_dut_15", {16'h0, cnt_a}, 32'd15);
        for (int i = 0; i < 3; i++) begin
            write_edge(5'(20 + i), 32'(i), 32'h300);
        end
        we = 1'b0;
        check("sat_alt_hold", {28'h0, cnt_b}, 32'd15);
        check("sat_dut_18", {16'h0, cnt_a}, 32'd18);

        // asynchronous reset mid-cycle clears state and pending trace
        ra1 = 5'd9;
        write_edge(5'd9, 32'hABCD, 32'h400);
        we = 1'b0;
        check("r9_rd1", rd1_a, 32'hABCD);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rd1", rd1_a, 32'h0);
        check("arst_tvalid", {31'h0, tvalid_a}, 32'h0);
        check("arst_tdata", tdata_a, 32'h0);
        check("arst_taddr", {27'h0, taddr_a}, 32'h0);
        check("arst_cnt", {16'h0, cnt_a}, 32'h0);
        check("arst_cnt_alt", {28'h0, cnt_b}, 32'h0);

        // writes ignored while in reset
        ra1 = 5'd3;
        we = 1'b1; wa = 5'd3; wd = 32'h55; pc = 32'h500;
        #1;
        check("inrst_byp_rd1", rd1_a, 32'h0);
        @(posedge clk);
        #1;
        check("inrst_rd1", rd1_a, 32'h0);
        check("inrst_cnt", {16'h0, cnt_a}, 32'h0);
        check("inrst_tvalid", {31'h0, tvalid_a}, 32'h0);
        @(negedge clk);
        we = 1'b0;
        reset_n = 1'b1;
        #1;
        check("postrst_rd1", rd1_a, 32'h0);

        // first commit after reset
        write_edge(5'd3, 32'h77, 32'h600);
        we = 1'b0;
        check("first_cnt", {16'h0, cnt_a}, 32'd1);
        check("first_rd1", rd1_a, 32'h77);
        check("first_tvalid", {31'h0, tvalid_a}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
